// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand, HI/LO write and result bundle between the pipeline and the multiply/divide unit.
// Latency: none, plain wires.
// Backpressure: busy is the only flow control; the pipeline holds mfhi/mflo/muldiv ops while it is high.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into the HI/LO registers, plus mthi/mtlo writes.
// Latency: start at edge 0 -> busy in cycles 1..WIDTH+1, HI/LO and done update in cycle WIDTH+2.
// Backpressure: none accepted; busy stalls the pipeline and start/mthi/mtlo seen while busy are dropped.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Latched operation context
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;       // product / quotient must be negated
  logic             neg_a_q, neg_a_d;   // dividend was negative: remainder follows it
  logic             dz_q, dz_d;         // divisor was zero
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude

  // Working registers: {wh, wl} is the shifting product, or remainder:quotient
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;

  // Architectural state
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand decode and per-iteration arithmetic
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE);

  // Operand magnitudes, one shift-add / restoring-subtract step, and sign-corrected results
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift the pair right
    mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: shift the next dividend bit into the remainder, subtract if it fits
    div_shift = {wh_q, wl_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ge    = ~div_diff[WIDTH+1];

    prod_mag  = {wh_q, wl_q};
    prod_fix  = neg_q ? -prod_mag : prod_mag;
    quo_fix   = neg_q ? -wl_q : wl_q;
    rem_fix   = neg_a_q ? -wh_q : wh_q;
  end

  // FSM next state: IDLE -> RUN for WIDTH iterations -> FIN -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath next state: latch on start, iterate in RUN, commit HI/LO in FIN
  always_comb begin
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_a_d  = neg_a_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // start wins over a simultaneous mthi/mtlo
          is_div_d = bus.op[1];
          neg_d    = a_neg ^ b_neg;
          neg_a_d  = a_neg;
          dz_d     = (bus.b == '0);
          wh_d     = '0;
          if (bus.op[1]) begin
            opnd_d = b_mag;
            wl_d   = a_mag;
          end else begin
            opnd_d = a_mag;
            wl_d   = b_mag;
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          // Remainder is always below the divisor, so the low WIDTH bits are enough
          wh_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          wl_d = {wl_q[WIDTH-2:0], div_ge};
        end else begin
          wh_d = mul_sum[WIDTH:1];
          wl_d = {mul_sum[0], wl_q[WIDTH-1:1]};
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude as remainder, so HI = a after sign fix
          hi_d = rem_fix;
          lo_d = dz_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State and iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath and architectural HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      wh_q     <= '0;
      wl_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_a_q  <= neg_a_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_unit_if #(.WIDTH(W)) mif ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: results straight from integer arithmetic and the documented corner rules
  function automatic void model(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                                output logic [31:0] hi_e, output logic [31:0] lo_e);
    longint      pa, pb, ps;
    logic [63:0] pu;
    int          sa, sb, q, r;
    hi_e = '0;
    lo_e = '0;
    case (op_v)
      OP_MULT: begin
        pa = longint'($signed(a_v));
        pb = longint'($signed(b_v));
        ps = pa * pb;
        pu = ps;
        hi_e = pu[63:32];
        lo_e = pu[31:0];
      end
      OP_MULTU: begin
        pu = {32'b0, a_v} * {32'b0, b_v};
        hi_e = pu[63:32];
        lo_e = pu[31:0];
      end
      OP_DIV: begin
        sa = a_v;
        sb = b_v;
        if (b_v == 32'd0) begin
          lo_e = 32'hFFFFFFFF;
          hi_e = a_v;
        end else if (a_v == 32'h80000000 && b_v == 32'hFFFFFFFF) begin
          lo_e = 32'h80000000;
          hi_e = 32'd0;
        end else begin
          q = sa / sb;
          r = sa % sb;
          lo_e = q;
          hi_e = r;
        end
      end
      default: begin
        if (b_v == 32'd0) begin
          lo_e = 32'hFFFFFFFF;
          hi_e = a_v;
        end else begin
          lo_e = a_v / b_v;
          hi_e = a_v % b_v;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 8))
      0: v = 32'h80000000;
      1: v = 32'hFFFFFFFF;
      2: v = 32'h7FFFFFFF;
      3: v = 32'd0;
      4: v = 32'($urandom_range(1, 20));
      5: v = -32'($urandom_range(1, 20));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Issue one operation at edge 0, watch cycles 1..W+2, return observations (no judging here)
  task automatic exec_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         output logic [31:0] hi_o, output logic [31:0] lo_o,
                         output int done_cyc, output int done_cnt, output int busy_err, output int hold_err);
    logic [31:0] hi0, lo0;
    done_cyc = 0;
    done_cnt = 0;
    busy_err = 0;
    hold_err = 0;
    @(negedge clk);
    hi0 = mif.hi;
    lo0 = mif.lo;
    mif.start = 1'b1;
    mif.op = op_v;
    mif.a = a_v;
    mif.b = b_v;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mif.start = 1'b0;
        mif.a = $urandom();
        mif.b = $urandom();
      end
      if (mif.busy !== (k <= W + 1)) busy_err++;
      if (mif.done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (k <= W + 1 && (mif.hi !== hi0 || mif.lo !== lo0)) hold_err++;
    end
    hi_o = mif.hi;
    lo_o = mif.lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mif.start = 1'b0;
    mif.op = 2'b00;
    mif.a = '0;
    mif.b = '0;
    mif.mthi = 1'b0;
    mif.mtlo = 1'b0;
    mif.wdata = '0;
    #3;
    checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", mif.hi); end
    checks++; if (mif.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", mif.lo); end
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mif.busy); end
    checks++; if (mif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mif.done); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] h, l;
    int dc, dn, be, he;
    exec_op(OP_MULT, 32'd7, 32'hFFFFFFFD, h, l, dc, dn, be, he);
    checks++; if (h !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", l); end
    checks++; if (dc !== 34 || dn !== 1) begin failures++; $display("FAIL mult_done cycle=%0d count=%0d exp cycle=34 count=1", dc, dn); end
    checks++; if (be !== 0 || he !== 0) begin failures++; $display("FAIL mult_busy_hold busy_err=%0d hold_err=%0d exp 0 0", be, he); end
    exec_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l, dc, dn, be, he);
    checks++; if (h !== 32'hFFFFFFFE || l !== 32'h00000001) begin failures++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", h, l); end
    exec_op(OP_DIV, 32'hFFFFFFF9, 32'd2, h, l, dc, dn, be, he);
    checks++; if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", h, l); end
    exec_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, h, l, dc, dn, be, he);
    checks++; if (l !== 32'h80000000 || h !== 32'd0) begin failures++; $display("FAIL div_min_m1 got hi=%h lo=%h exp hi=0 lo=80000000", h, l); end
    exec_op(OP_DIVU, 32'd100, 32'd0, h, l, dc, dn, be, he);
    checks++; if (l !== 32'hFFFFFFFF || h !== 32'd100) begin failures++; $display("FAIL divu_zero got hi=%h lo=%h exp hi=64 lo=ffffffff", h, l); end
    checks++; if (dc !== 34 || be !== 0) begin failures++; $display("FAIL divu_zero_latency cycle=%0d busy_err=%0d exp 34 0", dc, be); end
  endtask

  task automatic test_random_ops();
    logic [31:0] a_v, b_v, h, l, eh, el;
    logic [1:0]  op_v;
    int dc, dn, be, he;
    for (int i = 0; i < 64; i++) begin
      op_v = 2'(i % 4);
      a_v = pick();
      b_v = pick();
      model(op_v, a_v, b_v, eh, el);
      exec_op(op_v, a_v, b_v, h, l, dc, dn, be, he);
      checks++; if (h !== eh) begin failures++; $display("FAIL rand_hi op=%0d a=%h b=%h got=%h exp=%h", op_v, a_v, b_v, h, eh); end
      checks++; if (l !== el) begin failures++; $display("FAIL rand_lo op=%0d a=%h b=%h got=%h exp=%h", op_v, a_v, b_v, l, el); end
      checks++; if (dc !== W + 2 || dn !== 1 || be !== 0 || he !== 0) begin
        failures++; $display("FAIL rand_timing op=%0d done_cyc=%0d done_cnt=%0d busy_err=%0d hold_err=%0d exp 34 1 0 0", op_v, dc, dn, be, he);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] a_v, h, l;
    int dc, dn, be, he;
    for (int i = 0; i < 8; i++) begin
      a_v = (i == 0) ? 32'h80000000 : $urandom();
      exec_op((i % 2 == 0) ? OP_DIV : OP_DIVU, a_v, 32'd0, h, l, dc, dn, be, he);
      checks++; if (l !== 32'hFFFFFFFF || h !== a_v) begin failures++; $display("FAIL dz i=%0d a=%h got hi=%h lo=%h exp hi=%h lo=ffffffff", i, a_v, h, l, a_v); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h0, l0;
    int seen;
    @(negedge clk);
    l0 = mif.lo;
    mif.mthi = 1'b1;
    mif.wdata = 32'h0BADF00D;
    @(negedge clk);
    mif.mthi = 1'b0;
    checks++; if (mif.hi !== 32'h0BADF00D || mif.lo !== l0) begin failures++; $display("FAIL mthi got hi=%h lo=%h exp hi=0badf00d lo=%h", mif.hi, mif.lo, l0); end
    h0 = mif.hi;
    mif.mtlo = 1'b1;
    mif.wdata = 32'h13572468;
    @(negedge clk);
    mif.mtlo = 1'b0;
    checks++; if (mif.lo !== 32'h13572468 || mif.hi !== h0) begin failures++; $display("FAIL mtlo got hi=%h lo=%h exp hi=%h lo=13572468", mif.hi, mif.lo, h0); end
    mif.mthi = 1'b1;
    mif.mtlo = 1'b1;
    mif.wdata = 32'hCAFEBABE;
    @(negedge clk);
    mif.mthi = 1'b0;
    mif.mtlo = 1'b0;
    checks++; if (mif.hi !== 32'hCAFEBABE || mif.lo !== 32'hCAFEBABE) begin failures++; $display("FAIL mt_both got hi=%h lo=%h exp cafebabe", mif.hi, mif.lo); end
    // start and mthi together: write is dropped, operation runs
    mif.start = 1'b1;
    mif.op = OP_MULTU;
    mif.a = 32'd2;
    mif.b = 32'd3;
    mif.mthi = 1'b1;
    mif.wdata = 32'h5555AAAA;
    seen = 0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mif.start = 1'b0;
        mif.mthi = 1'b0;
        checks++; if (mif.hi !== 32'hCAFEBABE || mif.busy !== 1'b1) begin failures++; $display("FAIL start_wins_c1 hi=%h busy=%b exp hi=cafebabe busy=1", mif.hi, mif.busy); end
      end
      if (mif.hi === 32'h5555AAAA) seen++;
    end
    checks++; if (mif.hi !== 32'd0 || mif.lo !== 32'd6 || mif.done !== 1'b1 || seen !== 0) begin
      failures++; $display("FAIL start_wins_result hi=%h lo=%h done=%b seen=%0d exp hi=0 lo=6 done=1 seen=0", mif.hi, mif.lo, mif.done, seen);
    end
  endtask

  task automatic test_busy_ignore();
    int dn, dc, bad;
    dn = 0;
    dc = 0;
    bad = 0;
    @(negedge clk);
    mif.start = 1'b1;
    mif.op = OP_DIVU;
    mif.a = 32'd10;
    mif.b = 32'd3;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (mif.done === 1'b1) begin
        dn++;
        if (dc == 0) dc = k;
      end
      if (mif.hi === 32'd25 || mif.lo === 32'd25 || mif.hi === 32'h1234) bad++;
      if (k == W + 2) begin
        checks++; if (mif.hi !== 32'd1 || mif.lo !== 32'd3) begin failures++; $display("FAIL busy_ignore_result hi=%h lo=%h exp hi=1 lo=3", mif.hi, mif.lo); end
      end
      mif.start = 1'b0;
      mif.mthi = 1'b0;
      if (k == 5) begin
        mif.start = 1'b1;
        mif.op = OP_MULTU;
        mif.a = 32'd5;
        mif.b = 32'd5;
      end
      if (k == 6) begin
        mif.mthi = 1'b1;
        mif.wdata = 32'h1234;
      end
    end
    checks++; if (dn !== 1 || dc !== W + 2) begin failures++; $display("FAIL busy_ignore_done count=%0d cycle=%0d exp 1 34", dn, dc); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL busy_ignore_leak cycles=%0d exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
    int dc2;
    a1 = $urandom();
    b1 = $urandom();
    a2 = $urandom();
    b2 = 32'($urandom_range(1, 1000));
    model(OP_MULTU, a1, b1, eh1, el1);
    model(OP_DIV, a2, b2, eh2, el2);
    dc2 = 0;
    @(negedge clk);
    mif.start = 1'b1;
    mif.op = OP_MULTU;
    mif.a = a1;
    mif.b = b1;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) mif.start = 1'b0;
    end
    checks++; if (mif.done !== 1'b1 || mif.hi !== eh1 || mif.lo !== el1) begin
      failures++; $display("FAIL b2b_first done=%b hi=%h lo=%h exp done=1 hi=%h lo=%h", mif.done, mif.hi, mif.lo, eh1, el1);
    end
    mif.start = 1'b1;
    mif.op = OP_DIV;
    mif.a = a2;
    mif.b = b2;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mif.start = 1'b0;
        checks++; if (mif.busy !== 1'b1 || mif.done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b exp busy=1 done=0", mif.busy, mif.done); end
      end
      if (mif.done === 1'b1 && dc2 == 0) dc2 = k;
    end
    checks++; if (dc2 !== W + 2 || mif.hi !== eh2 || mif.lo !== el2) begin
      failures++; $display("FAIL b2b_second cycle=%0d hi=%h lo=%h exp cycle=34 hi=%h lo=%h", dc2, mif.hi, mif.lo, eh2, el2);
    end
  endtask

  task automatic test_reset_mid();
    int dn, be, he;
    logic [31:0] a_v, b_v, h, l, eh, el;
    int dc, rdn, rbe, rhe;
    @(negedge clk);
    mif.mthi = 1'b1;
    mif.mtlo = 1'b1;
    mif.wdata = 32'hDEADBEEF;
    @(negedge clk);
    mif.mthi = 1'b0;
    mif.mtlo = 1'b0;
    mif.start = 1'b1;
    mif.op = OP_MULT;
    mif.a = $urandom();
    mif.b = $urandom();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) mif.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++; if (mif.hi !== 32'd0 || mif.lo !== 32'd0) begin failures++; $display("FAIL rst_mid_hilo hi=%h lo=%h exp 0 0", mif.hi, mif.lo); end
    checks++; if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin failures++; $display("FAIL rst_mid_flags busy=%b done=%b exp 0 0", mif.busy, mif.done); end
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    be = 0;
    he = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (mif.done === 1'b1) dn++;
      if (mif.busy !== 1'b0) be++;
      if (mif.hi !== 32'd0 || mif.lo !== 32'd0) he++;
    end
    checks++; if (dn !== 0 || be !== 0 || he !== 0) begin failures++; $display("FAIL rst_mid_abandon done=%0d busy=%0d hilo=%0d exp 0 0 0", dn, be, he); end
    mif.mtlo = 1'b1;
    mif.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    mif.mtlo = 1'b0;
    checks++; if (mif.lo !== 32'hA5A5A5A5 || mif.hi !== 32'd0) begin failures++; $display("FAIL rst_mid_mtlo lo=%h hi=%h exp lo=a5a5a5a5 hi=0", mif.lo, mif.hi); end
    a_v = $urandom();
    b_v = $urandom();
    model(OP_MULT, a_v, b_v, eh, el);
    exec_op(OP_MULT, a_v, b_v, h, l, dc, rdn, rbe, rhe);
    checks++; if (h !== eh || l !== el || dc !== W + 2) begin failures++; $display("FAIL rst_recover hi=%h lo=%h cycle=%0d exp hi=%h lo=%h cycle=34", h, l, dc, eh, el); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random_ops();
    test_div_by_zero();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
